// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered RISC-V immediate generator with optional skid buffer
module imm_gen_stage #(
  parameter int XLEN    = 32,
  parameter bit SKID    = 1'b1,
  parameter bit EN_ZIMM = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc
);
  localparam logic [2:0] F_NONE = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                         F_U = 3'd4, F_J = 3'd5, F_Z = 3'd6;
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] tgt;
    logic [XLEN-1:0] pc;
  } res_t;
  logic [6:0]      op;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;
  logic [2:0]      fmt_d;
  res_t            new_d, o_q, s_q;
  logic            o_v_q, s_v_q, o_free, in_fire;
  assign op    = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
  assign imm_z = XLEN'(in_instr[19:15]);
  // Classify the opcode into an immediate format
  always_comb begin
    fmt_d = F_NONE;
    case (op)
      7'b0000011, 7'b0000111, 7'b0010011, 7'b1100111: fmt_d = F_I;
      7'b0011011: fmt_d = (XLEN == 64) ? F_I : F_NONE;
      7'b0100011, 7'b0100111: fmt_d = F_S;
      7'b1100011: fmt_d = F_B;
      7'b0110111, 7'b0010111: fmt_d = F_U;
      7'b1101111: fmt_d = F_J;
      7'b1110011: fmt_d = (EN_ZIMM && f3[2] && f3[1:0] != 2'b00) ? F_Z : F_NONE;
      default: fmt_d = F_NONE;
    endcase
  end
  // Pick the immediate and the PC-relative target (branches, jumps, AUIPC only)
  always_comb begin
    new_d.fmt = fmt_d;
    new_d.imm = fmt_d == F_I ? imm_i :
                fmt_d == F_S ? imm_s :
                fmt_d == F_B ? imm_b :
                fmt_d == F_U ? imm_u :
                fmt_d == F_J ? imm_j :
                fmt_d == F_Z ? imm_z : '0;
    new_d.tgt = (fmt_d == F_B || fmt_d == F_J || op == 7'b0010111) ? in_pc + new_d.imm : '0;
    new_d.pc  = in_pc;
  end
  assign o_free   = !o_v_q || out_ready;
  assign in_ready = !rst && (SKID ? !s_v_q : o_free);
  assign in_fire  = in_valid && in_ready;
  // Output register refills from skid first, then from input; skid catches input during a stall
  always_ff @(posedge clk) begin
    if (rst) begin
      o_v_q <= 1'b0;
      s_v_q <= 1'b0;
      o_q   <= '0;
      s_q   <= '0;
    end else begin
      if (o_free) begin
        o_v_q <= s_v_q || in_fire;
        if (s_v_q) o_q <= s_q;
        else if (in_fire) o_q <= new_d;
      end
      if (s_v_q && o_free) s_v_q <= 1'b0;
      else if (SKID && in_fire && !o_free) begin
        s_v_q <= 1'b1;
        s_q   <= new_d;
      end
    end
  end
  assign out_valid  = o_v_q;
  assign out_imm    = o_q.imm;
  assign out_fmt    = o_q.fmt;
  assign out_target = o_q.tgt;
  assign out_pc     = o_q.pc;
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: checks an RV32/skid/zimm instance and an RV64/no-skid/no-zimm instance
module tb_imm_gen_stage;
  typedef struct packed {
    logic [31:0] w;
    logic [63:0] pc;
  } item_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        out_ready = 1'b0;
  logic        iv[2];
  logic [31:0] ins[2];
  logic [63:0] ipc[2];
  logic        ir0, ov0, ir1, ov1;
  logic [31:0] imm0, tgt0, pc0;
  logic [63:0] imm1, tgt1, pc1;
  logic [2:0]  fmt0, fmt1;
  logic [63:0] oimm[2], otgt[2], opc[2];
  logic [2:0]  ofmt[2];
  logic        oir[2], oov[2];
  int          n_assert = 0;
  int          n_fail = 0;
  item_t       list[$];
  int          idx[2];
  int          odx[2];
  always #5 clk = ~clk;
  imm_gen_stage #(.XLEN(32), .SKID(1'b1), .EN_ZIMM(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .in_instr(ins[0]), .in_pc(ipc[0][31:0]),
    .out_valid(ov0), .out_ready(out_ready), .out_imm(imm0), .out_fmt(fmt0), .out_target(tgt0), .out_pc(pc0)
  );
  imm_gen_stage #(.XLEN(64), .SKID(1'b0), .EN_ZIMM(1'b0)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .in_instr(ins[1]), .in_pc(ipc[1]),
    .out_valid(ov1), .out_ready(out_ready), .out_imm(imm1), .out_fmt(fmt1), .out_target(tgt1), .out_pc(pc1)
  );
  always_comb begin
    oimm[0] = {32'b0, imm0}; otgt[0] = {32'b0, tgt0}; opc[0] = {32'b0, pc0}; ofmt[0] = fmt0;
    oimm[1] = imm1;          otgt[1] = tgt1;          opc[1] = pc1;          ofmt[1] = fmt1;
    oir[0] = ir0; oov[0] = ov0; oir[1] = ir1; oov[1] = ov1;
  end
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, e);
    end
  endtask
  // Reference: immediates built from the field layout with plain integer arithmetic
  function automatic void model(input int xl, input bit ez, input logic [31:0] w, input logic [63:0] pc,
                                output logic [63:0] imm, output logic [2:0] fmt, output logic [63:0] tgt);
    logic [63:0] m;
    longint v;
    bit rel;
    m = (xl == 32) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    v = 0;
    rel = 0;
    fmt = 0;
    case (w[6:0])
      7'h03, 7'h07, 7'h13, 7'h67, 7'h1B: begin
        if (w[6:0] != 7'h1B || xl == 64) begin
          fmt = 1; v = w[31:20]; if (w[31]) v -= 4096;
        end
      end
      7'h23, 7'h27: begin fmt = 2; v = {w[31:25], w[11:7]}; if (w[31]) v -= 4096; end
      7'h63: begin fmt = 3; rel = 1; v = {w[31], w[7], w[30:25], w[11:8], 1'b0}; if (w[31]) v -= 8192; end
      7'h37, 7'h17: begin
        fmt = 4; rel = (w[6:0] == 7'h17); v = w[31:12]; v = v * 4096;
        if (w[31]) v -= 64'sh1_0000_0000;
      end
      7'h6F: begin fmt = 5; rel = 1; v = {w[31], w[19:12], w[20], w[30:21], 1'b0}; if (w[31]) v -= 2097152; end
      7'h73: if (ez && w[14:12] >= 5) begin fmt = 6; v = w[19:15]; end
      default: ;
    endcase
    imm = v & m;
    tgt = rel ? (pc + v) & m : 64'd0;
  endfunction
  task automatic direct(input string tag, input logic [31:0] w, input logic [63:0] pc,
                        input logic [31:0] i32, input logic [2:0] f32, input logic [31:0] t32,
                        input logic [63:0] i64, input logic [2:0] f64, input logic [63:0] t64);
    for (int d = 0; d < 2; d++) begin iv[d] = 1'b1; ins[d] = w; ipc[d] = pc; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0; iv[1] = 1'b0;
    chk({tag, ".v32"}, ov0, 1'b1);
    chk({tag, ".imm32"}, imm0, i32);
    chk({tag, ".fmt32"}, fmt0, f32);
    chk({tag, ".tgt32"}, tgt0, t32);
    chk({tag, ".pc32"}, pc0, pc[31:0]);
    chk({tag, ".v64"}, ov1, 1'b1);
    chk({tag, ".imm64"}, imm1, i64);
    chk({tag, ".fmt64"}, fmt1, f64);
    chk({tag, ".tgt64"}, tgt1, t64);
    chk({tag, ".pc64"}, pc1, pc);
  endtask
  // One cycle of streaming from the shared item list; each instance keeps its own accept/emit position
  task automatic step(input bit ordy);
    bit fin[2], fout[2];
    logic [63:0] e_imm, e_tgt, m;
    logic [2:0] e_fmt;
    int held;
    out_ready = ordy;
    for (int d = 0; d < 2; d++) begin
      iv[d] = idx[d] < list.size();
      if (iv[d]) begin ins[d] = list[idx[d]].w; ipc[d] = list[idx[d]].pc; end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      held = idx[d] - odx[d];
      m = (d == 0) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      chk($sformatf("in_ready[%0d]", d), oir[d], (d == 0) ? (held < 2) : (held == 0 || ordy));
      chk($sformatf("out_valid[%0d]", d), oov[d], held > 0);
      if (held > 0) begin
        model(d == 0 ? 32 : 64, d == 0, list[odx[d]].w, list[odx[d]].pc & m, e_imm, e_fmt, e_tgt);
        chk($sformatf("imm[%0d]#%0d", d, odx[d]), oimm[d], e_imm);
        chk($sformatf("fmt[%0d]#%0d", d, odx[d]), ofmt[d], e_fmt);
        chk($sformatf("tgt[%0d]#%0d", d, odx[d]), otgt[d], e_tgt);
        chk($sformatf("pc[%0d]#%0d", d, odx[d]), opc[d], list[odx[d]].pc & m);
      end
      fin[d] = iv[d] && oir[d];
      fout[d] = oov[d] && ordy;
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      if (fin[d]) idx[d]++;
      if (fout[d]) odx[d]++;
    end
  endtask
  function automatic item_t rnd_item();
    logic [6:0] ops[13] = '{7'h03, 7'h07, 7'h13, 7'h67, 7'h1B, 7'h23, 7'h27, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33};
    item_t it;
    it.w = $urandom();
    if ($urandom_range(0, 7) != 0) it.w[6:0] = ops[$urandom_range(0, 12)];
    it.pc = {$urandom(), $urandom()};
    return it;
  endfunction
  initial begin
    int base;
    idx[0] = 0; idx[1] = 0; odx[0] = 0; odx[1] = 0;
    for (int d = 0; d < 2; d++) begin iv[d] = 1'b1; ins[d] = 32'hFFF00093; ipc[d] = 64'h40; end
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst.ov32", ov0, 1'b0);
      chk("rst.ov64", ov1, 1'b0);
      chk("rst.ir32", ir0, 1'b0);
      chk("rst.ir64", ir1, 1'b0);
    end
    chk("rst.imm32", imm0, 32'd0);
    chk("rst.fmt64", fmt1, 3'd0);
    chk("rst.tgt64", tgt1, 64'd0);
    chk("rst.pc32", pc0, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst.ir32", ir0, 1'b1);
    chk("post_rst.ir64", ir1, 1'b1);
    iv[0] = 1'b0; iv[1] = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst.ov32", ov0, 1'b0);
    chk("post_rst.ov64", ov1, 1'b0);
    direct("addi", 32'hFFF00093, 64'h1000, 32'hFFFFFFFF, 3'd1, 32'd0, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 64'd0);
    direct("beq", 32'hFE000EE3, 64'h100, 32'hFFFFFFFC, 3'd3, 32'hFC, 64'hFFFFFFFF_FFFFFFFC, 3'd3, 64'hFC);
    direct("beq0", 32'hFE000EE3, 64'h0, 32'hFFFFFFFC, 3'd3, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd3, 64'hFFFFFFFF_FFFFFFFC);
    direct("lui", 32'h123452B7, 64'h40, 32'h12345000, 3'd4, 32'd0, 64'h12345000, 3'd4, 64'd0);
    direct("csrrwi", 32'h300FD073, 64'h80, 32'h1F, 3'd6, 32'd0, 64'd0, 3'd0, 64'd0);
    direct("csrrw", 32'h30029073, 64'h80, 32'd0, 3'd0, 32'd0, 64'd0, 3'd0, 64'd0);
    direct("addiw", 32'hFFF0809B, 64'h80, 32'd0, 3'd0, 32'd0, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 64'd0);
    direct("auipc", 32'h80000017, 64'h80000000, 32'h80000000, 3'd4, 32'd0, 64'hFFFFFFFF_80000000, 3'd4, 64'd0);
    direct("jal", 32'h0040006F, 64'h200, 32'd4, 3'd5, 32'h204, 64'd4, 3'd5, 64'h204);
    direct("sb", 32'hFE000C23, 64'h300, 32'hFFFFFFF8, 3'd2, 32'd0, 64'hFFFFFFFF_FFFFFFF8, 3'd2, 64'd0);
    direct("none", 32'h0000007F, 64'h300, 32'd0, 3'd0, 32'd0, 64'd0, 3'd0, 64'd0);
    @(posedge clk); #1;
    chk("drain.ov32", ov0, 1'b0);
    chk("drain.ov64", ov1, 1'b0);
    base = list.size();
    repeat (4) list.push_back(rnd_item());
    step(1); step(1); step(0); step(0); step(1); step(1);
    chk("stall.acc32", idx[0], base + 4);
    chk("stall.acc64", idx[1], base + 4);
    step(1);
    chk("stall.out32", odx[0], base + 4);
    chk("stall.out64", odx[1], base + 4);
    repeat (3) list.push_back(rnd_item());
    step(1); step(0); step(0);
    iv[0] = 1'b0; iv[1] = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst.ov32", ov0, 1'b0);
    chk("midrst.ov64", ov1, 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst.ir32", ir0, 1'b1);
    for (int d = 0; d < 2; d++) begin idx[d] = list.size(); odx[d] = list.size(); end
    step(1);
    repeat (200) list.push_back(rnd_item());
    for (int c = 0; c < 2000 && (odx[0] < list.size() || odx[1] < list.size()); c++)
      step($urandom_range(0, 3) != 0);
    chk("rand.done32", odx[0], list.size());
    chk("rand.done64", odx[1], list.size());
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Parametrised, registered immediate-generation stage between fetch and decode/execute. It accepts one 32-bit instruction and its PC per valid/ready handshake. It produces the XLEN-wide sign- or zero-extended immediate, a format code, and the PC-relative target. It generalises the combinational immediate unit to RV32/RV64, adds CSR zimm, OP-IMM-32 and a skid buffer for full-throughput backpressure.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
SKID, 1, 1 = two-entry registered-ready skid buffer; 0 = single register with combinational ready
EN_ZIMM, 1, 1 = decode CSR immediate forms; 0 = treat them as format NONE

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream holds an instruction
in_ready  out  1  stage can accept this cycle
in_instr  in  32  raw instruction word
in_pc  in  XLEN  PC of in_instr
out_valid  out  1  out_* hold a result
out_ready  in  1  downstream accepts
out_imm  out  XLEN  extended immediate
out_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z
out_target  out  XLEN  PC + imm for B, J, AUIPC; else 0
out_pc  out  XLEN  registered copy of in_pc

Behaviour:
- Reset (rst high at an edge): out_valid=0; out_imm, out_fmt, out_target, out_pc = 0; skid emptied.
- in_ready reads 0 while rst is high and 1 the cycle after.
- rst mid-transfer drops any held or skidded entry. No partial output is ever presented.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Latency: 1 cycle. An input accepted at edge N is on out_* after edge N when the output register is free.
- out_* stay stable while out_valid & !out_ready.
- SKID=1:
  - in_ready is registered and equals "skid empty".
  - Input accepted while the output is stalled goes into the skid entry.
  - On the next out transfer, skid moves into the output register and in_ready returns to 1 the following cycle.
  - Sustained throughput is 1 per cycle; order is strictly FIFO.
- SKID=0: in_ready = !out_valid | out_ready, combinational.
- Simultaneous in and out transfer: the output register takes the new (or skid) entry, with no bubble.
- Decode on in_instr[6:0]; sext = sign-extend to XLEN:
  - 0000011, 0000111, 0010011, 1100111 -> I: sext(in[31:20]).
  - 0011011 (OP-IMM-32) -> I only when XLEN=64; when XLEN=32 -> NONE.
  - 0100011, 0100111 -> S: sext({in[31:25], in[11:7]}).
  - 1100011 -> B: sext({in[31], in[7], in[30:25], in[11:8], 0}).
  - 0110111, 0010111 -> U: sext({in[31:12], 12'b0}). Bit 31 is sign-extended for XLEN=64.
  - 1101111 -> J: sext({in[31], in[19:12], in[20], in[30:21], 0}).
  - 1110011 with funct3 in {101, 110, 111} and EN_ZIMM=1 -> Z: zero-extend in[19:15].
  - All other encodings, including other SYSTEM funct3 -> NONE, imm=0.
- out_target = (in_pc + imm) mod 2^XLEN for B, J and AUIPC (0010111); 0 otherwise, including LUI. Carry out is discarded (wrap-around).
- No illegal-instruction signalling; NONE is the only indication.

Test Plan:
- rst held 3 cycles with in_valid=1 -> out_valid=0, in_ready=0 during reset; in_ready=1 the cycle after rst falls; nothing is captured during reset.
- XLEN=32, in_instr=0xFFF00093 (addi -1) -> next cycle out_imm=0xFFFFFFFF, out_fmt=1, out_target=0.
- in_instr=0xFE000EE3 (beq -4), in_pc=0x100 -> out_imm=0xFFFFFFFC, fmt=3, target=0xFC. With in_pc=0x0 -> target=0xFFFFFFFC (wrap).
- in_instr=0x123452B7 (lui) -> imm=0x12345000, fmt=4, target=0. in_instr=0x300FD073 (csrrwi, zimm 31) -> imm=0x1F, fmt=6; with EN_ZIMM=0 -> fmt=0, imm=0.
- XLEN=64, in_instr=0xFFF0809B (addiw -1) -> imm=0xFFFFFFFFFFFFFFFF, fmt=1. The same word with XLEN=32 -> fmt=0, imm=0.
- SKID=1, stream 4 back-to-back instructions with out_ready low for 2 cycles mid-stream:
  - in_ready drops exactly one cycle after the skid fills.
  - All 4 results emerge in order, unduplicated, with out_* stable while stalled.
  - Full rate resumes after out_ready returns high.
